// File: rtl/mux_sel_sequencer_pkg.sv
// Shared types and helpers for the three-input steering mux sequencer.
// Source/state encodings and the source-to-select mapping live here.
package mux_sel_pkg;

  localparam int NUM_SRC = 3;

  typedef enum logic [1:0] {
    SRC_A = 2'd0,
    SRC_B = 2'd1,
    SRC_C = 2'd2
  } src_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Returns {sel_2, sel_1}; 2'b11 is never produced.
  function automatic logic [1:0] src_to_sel(input src_e src);
    case (src)
      SRC_B:   return 2'b01;
      SRC_C:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mux_sel_sequencer_if.sv
// Request/grant/select bundle between the sources, the sequencer and the mux.
// The sequencer sits on the slave side; the requesting environment is master.
interface mux_sel_sequencer_if;
  import mux_sel_pkg::*;

  logic [NUM_SRC-1:0] req;
  logic               sel_1;
  logic               sel_2;
  logic [NUM_SRC-1:0] gnt;
  logic [1:0]         gnt_idx;
  logic               out_valid;

  modport master (output req, input sel_1, sel_2, gnt, gnt_idx, out_valid);
  modport slave  (input req, output sel_1, sel_2, gnt, gnt_idx, out_valid);

endinterface

// File: rtl/mux_sel_sequencer_rr_pick3.sv
// Combinational round-robin picker over three sources.
// Search starts at the source after 'last' and wraps a -> b -> c -> a.
module rr_pick3
  import mux_sel_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  src_e               last,
  output src_e               pick,
  output logic               any_req
);

  always_comb begin
    pick    = SRC_A;
    any_req = |req;
    case (last)
      SRC_A: begin
        if (req[1])      pick = SRC_B;
        else if (req[2]) pick = SRC_C;
        else             pick = SRC_A;
      end
      SRC_B: begin
        if (req[2])      pick = SRC_C;
        else if (req[0]) pick = SRC_A;
        else             pick = SRC_B;
      end
      default: begin
        if (req[0])      pick = SRC_A;
        else if (req[1]) pick = SRC_B;
        else             pick = SRC_C;
      end
    endcase
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Round-robin grant sequencer driving the a/b/c steering mux selects.
// Holds each grant for DWELL cycles and inserts a one-cycle break-before-make gap.
//
// state | meaning
// IDLE  | no grant, arbitrate every cycle
// GRANT | owner drives mux, dwell counter running
// GAP   | one dead cycle, selects held, re-arbitrate at its end
module mux_sel_sequencer
  import mux_sel_pkg::*;
#(
  parameter int DWELL     = 4,
  parameter bit EARLY_REL = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  mux_sel_sequencer_if.slave  bus
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      dwell_q, dwell_d;
  src_e               owner_q, owner_d;
  src_e               last_q, last_d;
  logic [1:0]         sel_q, sel_d;
  logic [NUM_SRC-1:0] gnt_q, gnt_d;
  logic [1:0]         gnt_idx_q, gnt_idx_d;
  logic               out_valid_q, out_valid_d;

  src_e pick;
  logic any_req;

  rr_pick3 u_pick (
    .req     (bus.req),
    .last    (last_q),
    .pick    (pick),
    .any_req (any_req)
  );

  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    owner_d     = owner_q;
    last_d      = last_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    out_valid_d = out_valid_q;
    case (state_q)
      GRANT: begin
        if (dwell_q == '0 || (EARLY_REL && !bus.req[owner_q])) begin
          state_d     = GAP;
          last_d      = owner_q;
          gnt_d       = '0;
          gnt_idx_d   = '0;
          out_valid_d = 1'b0;
        end else begin
          dwell_d = dwell_q - CW'(1);
        end
      end
      default: begin
        // IDLE and the end of GAP share the same arbitration; selects only
        // move when a new grant starts, so the mux never sees a glitch.
        if (any_req) begin
          state_d     = GRANT;
          owner_d     = pick;
          dwell_d     = DWELL_LOAD;
          sel_d       = src_to_sel(pick);
          gnt_d       = 3'b001 << pick;
          gnt_idx_d   = pick;
          out_valid_d = 1'b1;
        end else begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_idx_d   = '0;
          out_valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dwell_q     <= '0;
      owner_q     <= SRC_A;
      last_q      <= SRC_C;
      sel_q       <= 2'b00;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.sel_1     = sel_q[0];
  assign bus.sel_2     = sel_q[1];
  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.out_valid = out_valid_q;

endmodule
